// File: rtl/cdr_phase_picker.sv
// cdr_phase_picker: picks the sample phase of a 2x oversampled stream and packs recovered bits into words
module cdr_phase_picker #(
  parameter int OUT_WIDTH    = 8,
  parameter int ACC_WIDTH    = 6,
  parameter int THRESH       = 8,
  parameter int LOCK_NIBBLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [3:0]           in_data,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_phase,
  output logic                 out_locked
);
  localparam int BW  = OUT_WIDTH + 2;
  localparam int FW  = $clog2(OUT_WIDTH + 3);
  localparam int LW  = $clog2(LOCK_NIBBLES + 1);
  localparam int AW1 = ACC_WIDTH + 1;
  localparam logic signed [ACC_WIDTH:0] TP = AW1'(THRESH);
  localparam logic signed [ACC_WIDTH:0] TN = -TP;
  typedef enum logic {EVEN, ODD} phase_t;
  phase_t                      phase;
  logic                        prev, slip, sw, done;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH:0]   sum, acc_nx;
  logic signed [2:0]           delta;
  logic [3:0]                  e;
  logic [1:0]                  v_even, v_odd, n;
  logic [2:0]                  em;
  logic [BW-1:0]               bbuf, merged;
  logic [FW-1:0]               fill, tot;
  logic [LW-1:0]               cnt;
  always_comb begin
    e      = in_data ^ {in_data[2:0], prev};
    v_even = {1'b0, e[1]} + {1'b0, e[3]};
    v_odd  = {1'b0, e[0]} + {1'b0, e[2]};
    delta  = $signed({1'b0, v_even}) - $signed({1'b0, v_odd});
    sum    = AW1'(acc) + AW1'(delta);
    acc_nx = sum > TP ? TP : sum < TN ? TN : sum;
    sw     = phase == EVEN ? acc_nx == TN : acc_nx == TP;
    em     = slip ? (phase == ODD ? {in_data[3], in_data[1], prev} : {2'b0, in_data[2]})
                  : (phase == ODD ? {1'b0, in_data[3], in_data[1]} : {1'b0, in_data[2], in_data[0]});
    n      = slip ? (phase == ODD ? 2'd3 : 2'd1) : 2'd2;
    merged = bbuf | (BW'(em) << fill);
    tot    = fill + FW'(n);
    done   = tot >= FW'(OUT_WIDTH);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= EVEN;
      acc       <= '0;
      prev      <= 1'b0;
      slip      <= 1'b0;
      bbuf      <= '0;
      fill      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid && done;
      if (in_valid) begin
        prev  <= in_data[3];
        slip  <= sw;
        acc   <= sw ? '0 : acc_nx[ACC_WIDTH-1:0];
        phase <= sw ? (phase == EVEN ? ODD : EVEN) : phase;
        cnt   <= sw ? '0 : cnt == LW'(LOCK_NIBBLES) ? cnt : cnt + 1'b1;
        bbuf  <= done ? merged >> OUT_WIDTH : merged;
        fill  <= done ? tot - FW'(OUT_WIDTH) : tot;
        if (done) out_data <= merged[OUT_WIDTH-1:0];
      end
    end
  end
  assign out_phase  = phase == ODD;
  assign out_locked = cnt == LW'(LOCK_NIBBLES);
endmodule

// File: tb/tb_cdr_phase_picker.sv
// tb_cdr_phase_picker: randomized scoreboard bench with a bit-queue reference model
module tb_cdr_phase_picker;
  localparam int W  = 8;
  localparam int TH = 8;
  localparam int LN = 16;
  logic         clk = 1'b0;
  logic         rst, in_valid;
  logic [3:0]   in_data;
  logic         out_valid, out_phase, out_locked;
  logic [W-1:0] out_data;
  int           total = 0;
  int           bad = 0;
  bit           checking = 1'b0;
  int           m_acc, m_phase, m_prev, m_slip, m_lock;
  bit           m_ov;
  logic [W-1:0] m_word;
  bit           bq[$];
  logic [W-1:0] expq[$];
  cdr_phase_picker #(.OUT_WIDTH(W), .ACC_WIDTH(6), .THRESH(TH), .LOCK_NIBBLES(LN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_phase(out_phase), .out_locked(out_locked)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_step(input bit v, input logic [3:0] d, input bit r);
    int s[4];
    int e[4];
    int a;
    bit sw;
    logic [W-1:0] w;
    if (r) begin
      m_acc = 0; m_phase = 0; m_prev = 0; m_slip = 0; m_lock = 0;
      m_ov = 0; m_word = '0;
      bq.delete();
    end else if (!v) begin
      m_ov = 0;
    end else begin
      for (int i = 0; i < 4; i++) s[i] = int'(d[i]);
      e[0] = s[0] ^ m_prev;
      for (int i = 1; i < 4; i++) e[i] = s[i] ^ s[i-1];
      a = m_acc + (e[1] + e[3]) - (e[0] + e[2]);
      if (a > TH) a = TH;
      if (a < -TH) a = -TH;
      if (m_slip != 0 && m_phase != 0) begin
        bq.push_back(m_prev[0]); bq.push_back(s[1][0]); bq.push_back(s[3][0]);
      end else if (m_slip != 0) begin
        bq.push_back(s[2][0]);
      end else if (m_phase != 0) begin
        bq.push_back(s[1][0]); bq.push_back(s[3][0]);
      end else begin
        bq.push_back(s[0][0]); bq.push_back(s[2][0]);
      end
      sw = (m_phase != 0) ? (a == TH) : (a == -TH);
      m_acc  = sw ? 0 : a;
      m_phase = sw ? 1 - m_phase : m_phase;
      m_slip = int'(sw);
      m_prev = s[3];
      m_lock = sw ? 0 : (m_lock < LN ? m_lock + 1 : LN);
      m_ov = 0;
      if (bq.size() >= W) begin
        for (int i = 0; i < W; i++) w[i] = bq.pop_front();
        expq.push_back(w);
        m_word = w;
        m_ov = 1;
      end
    end
  endtask
  task automatic cyc(input bit v, input logic [3:0] d, input bit r);
    rst = r; in_valid = v; in_data = d;
    @(posedge clk);
    model_step(v, d, r);
    #1;
  endtask
  always @(negedge clk) begin
    if (checking) begin
      check("out_valid", out_valid, m_ov);
      if (out_valid) begin
        check("word_queued", expq.size() > 0, 1);
        if (expq.size() > 0) check("word_data", out_data, expq.pop_front());
      end
      check("out_data_hold", out_data, m_word);
      check("out_phase", out_phase, m_phase);
      check("out_locked", out_locked, m_lock == LN);
    end
  end
  initial begin
    bit smp[$];
    bit b;
    logic [3:0] nib;
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    cyc(0, 4'h0, 1);
    checking = 1'b1;
    for (int i = 0; i < 6; i++) cyc(1'($urandom), 4'($urandom), 1);
    check("rst_data", out_data, 0);
    check("rst_valid", out_valid, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 4'b0110, 0);
      cyc(0, 4'($urandom), 0);
    end
    check("even_phase", out_phase, 0);
    check("even_word", out_data, 8'hAA);
    check("even_locked", out_locked, 1);
    cyc(0, 4'h0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 4'b1100, 0);
    check("switch_odd", out_phase, 1);
    check("switch_unlock", out_locked, 0);
    for (int i = 0; i < 10; i++) cyc(1, 4'b1100, 0);
    for (int i = 0; i < 20; i++) cyc(1, 4'b0110, 0);
    check("back_even", out_phase, 0);
    for (int i = 0; i < 3; i++) cyc(1, 4'b0110, 0);
    cyc(1, 4'b1111, 1);
    cyc(0, 4'h0, 0);
    check("midword_rst_valid", out_valid, 0);
    for (int i = 0; i < 8; i++) cyc(1, 4'($urandom), 0);
    for (int i = 0; i < 2400; i++) begin
      b = 1'($urandom);
      smp.push_back(b);
      if ($urandom_range(0, 39) == 0) smp.push_back(b);
      if ($urandom_range(0, 39) != 0) smp.push_back(b);
    end
    while (smp.size() >= 4) begin
      if ($urandom_range(0, 299) == 0) begin
        cyc(1'($urandom), 4'($urandom), 1);
      end else if ($urandom_range(0, 3) == 0) begin
        cyc(0, 4'($urandom), 0);
      end else begin
        for (int i = 0; i < 4; i++) nib[i] = smp.pop_front();
        cyc(1, nib, 0);
      end
    end
    cyc(0, 4'h0, 0);
    checking = 1'b0;
    check("queue_drain", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cdr_phase_picker.md
# cdr_phase_picker

Phase-selection and bit-assembly stage directly downstream of the 2x oversampling sampler in the CDR data-recovery path. It consumes 4-sample nibbles: two bit periods, each sampled on the rising and falling clock edge. It detects data transitions, integrates them into a phase vote, and selects the sample phase farthest from the edges. It compensates the one-bit slip caused by each phase change and packs the recovered bits into `OUT_WIDTH`-bit words.

## Interface
- `OUT_WIDTH`, default 8: recovered word width. Must be ≥ 4.
- `ACC_WIDTH`, default 6: width of the signed phase-vote accumulator.
- `THRESH`, default 8: vote magnitude that triggers a phase switch. Must be ≤ 2^(ACC_WIDTH-1)-1.
- `LOCK_NIBBLES`, default 16: number of consecutive switch-free valid nibbles required before `out_locked` asserts.
- `clk`  in  1  single clock domain (sampler rising-edge clock).
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `in_valid`  in  1  nibble strobe. Any cadence is accepted, including back-to-back.
- `in_data`  in  4  samples `s0..s3`; `s0` = bit 0 = oldest. Order is pos, neg, pos, neg.
- `out_valid`  out  1  one-cycle pulse when a word is complete.
- `out_data`  out  OUT_WIDTH  recovered word. The first received bit is at bit 0.
- `out_phase`  out  1  current phase: 0 = EVEN (samples s0, s2), 1 = ODD (samples s1, s3).
- `out_locked`  out  1  phase has been stable for `LOCK_NIBBLES` consecutive nibbles.

## Operation
- **Registers.** `prev` holds the last sample (`s3`) of the previous valid nibble; reset value 0.
- **Edge detection.** Per valid nibble: `e0 = s0^prev`, `e1 = s1^s0`, `e2 = s2^s1`, `e3 = s3^s2`.
- **Votes.**
  - `v_even = e1 + e3`: edges before odd samples, so vote EVEN.
  - `v_odd = e0 + e2`: edges before even samples, so vote ODD.
  - `delta = v_even - v_odd`, range -2..+2.
- **Accumulator.** `acc_next = clamp(acc + delta, -THRESH, +THRESH)`, computed with signed arithmetic and no wrap.
- **Phase state machine.** Two states, EVEN and ODD; reset state is EVEN.
  - EVEN → ODD when `acc_next == -THRESH`; `acc` is set to 0.
  - ODD → EVEN when `acc_next == +THRESH`; `acc` is set to 0.
  - Otherwise `acc = acc_next`, so the accumulator saturates at the in-phase limit.
- **Bit emission.** Bits are taken LSB-first, using the phase in effect before this nibble's update.
  - Normal nibble, EVEN phase: emits `s0`, `s2`.
  - Normal nibble, ODD phase: emits `s1`, `s3`.
  - First nibble after an EVEN→ODD switch: emits `prev`, `s1`, `s3` (3 bits; recovers the skipped bit).
  - First nibble after an ODD→EVEN switch: emits `s2` only (1 bit; drops the duplicate `s0`).
  - A pending-slip flag records which correction applies to the next valid nibble.
- **Word assembler.**
  - Bit buffer of `OUT_WIDTH+2` bits with a fill count.
  - When `fill + n ≥ OUT_WIDTH`, the lowest `OUT_WIDTH` bits are output and the remainder carries over (starting at bit 0).
  - `out_data` holds its value between pulses.
- **Lock counter.**
  - Increments on each valid nibble without a switch, saturating at `LOCK_NIBBLES`.
  - Cleared to 0 on a switch.
  - `out_locked = (count == LOCK_NIBBLES)`.
- **Reset values.** `out_valid` 0, `out_data` 0, `out_phase` 0, `out_locked` 0. `acc`, fill, lock count, `prev` and the slip flag are all 0.

## Timing
- A nibble accepted in cycle t updates `acc`, phase, `prev`, the slip flag and the lock count in cycle t+1 (registered).
- A word completed by the nibble accepted in cycle t drives `out_valid` high in cycle t+1, for exactly one cycle.
- `out_phase` changes in cycle t+1 after the switching nibble. That switching nibble emits its bits with the old phase.
- Cycles with `in_valid` = 0 change nothing; `out_valid` is 0 in them.
- `rst` asserted in any cycle:
  - the partial word is discarded;
  - no `out_valid` is produced in that cycle or the next;
  - `in_data` sampled while `rst` is high is ignored.
- Throughput: one nibble per cycle sustained; at most one word per nibble.

## Test plan
- **Reset.** Hold `rst` with random `in_valid`/`in_data` → all outputs 0; after release the first word appears only after 4 nibbles.
- **Stable EVEN.** Stream `in_data` = 4'b0110 every 2 cycles → `out_phase` stays 0; `acc` saturates at +8; `out_data` = 8'hAA every 4th nibble; `out_locked` rises 1 cycle after the 16th nibble.
- **EVEN→ODD switch.** Stream 4'b1100 from reset → `delta` is -1 on nibble 1, then -2 per nibble; switch on nibble 5 (`out_phase` = 1 the next cycle); nibble 6 emits 3 bits `1,0,1`; later nibbles emit `0,1`; `out_locked` clears.
- **ODD→EVEN switch.** Stream 4'b1100 until ODD, then 4'b0110 → switch occurs after ≥ 4 nibbles; the next nibble emits only bit `s2` = 1; word boundaries shift by −1 bit.
- **Carry.** 3-bit slip nibble arriving with fill = 7 → word emitted with the 1 new bit at bit 7; the remaining 2 bits start the next word at bits 0–1.
- **Reset mid-word.** `rst` with fill = 5 → no `out_valid`; the next word is built only from post-reset nibbles; `prev` is 0.
